// File: rtl/csr_file_if.sv
// Decode-to-CSR request bus. The decoder drives the request and the CSR file
// answers combinationally with the old value and an illegal flag.
interface csr_file_if;
  logic        csr_valid;
  logic        csr_wen;
  logic        csr_use_imm;
  logic [1:0]  csr_mode;
  logic [11:0] csr_addr;
  logic [31:0] csr_rs1;
  logic [4:0]  csr_zimm;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_valid, csr_wen, csr_use_imm, csr_mode, csr_addr, csr_rs1, csr_zimm,
    input  csr_rdata, csr_illegal
  );
  modport slave (
    input  csr_valid, csr_wen, csr_use_imm, csr_mode, csr_addr, csr_rs1, csr_zimm,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/RS/RC(I) access, trap entry / mret state updates,
// 64-bit mcycle/minstret counters and the fetch redirect target.
module csr_file #(
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MHARTID_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_file_if.slave   csr,
  input  logic        retire,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] redirect_pc,
  output logic        mstatus_mie
);
  localparam logic [1:0] MODE_RW = 2'b01, MODE_RS = 2'b10;

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mie_r_q, mie_r_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic        hit, ill, do_wr;
  logic [31:0] old, op, nv, mstatus_rd, vec_base;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored.
  assign mstatus_rd  = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mstatus_mie = mie_q;

  always_comb begin
    hit = 1'b1;
    old = '0;
    case (csr.csr_addr)
      12'h300:          old = mstatus_rd;
      12'h301:          old = MISA_VAL;
      12'h304:          old = mie_r_q;
      12'h305:          old = mtvec_q;
      12'h340:          old = mscratch_q;
      12'h341:          old = mepc_q;
      12'h342:          old = mcause_q;
      12'h343:          old = mtval_q;
      12'h344:          old = '0;
      12'hB00, 12'hC00: old = mcycle_q[31:0];
      12'hB80, 12'hC80: old = mcycle_q[63:32];
      12'hB02, 12'hC02: old = minstret_q[31:0];
      12'hB82, 12'hC82: old = minstret_q[63:32];
      12'hF14:          old = MHARTID_VAL;
      default:          hit = 1'b0;
    endcase
  end

  assign ill = csr.csr_valid & (~hit | (csr.csr_mode == 2'b00) |
               (csr.csr_wen & (csr.csr_addr[11:10] == 2'b11)));
  assign csr.csr_illegal = ill;
  assign csr.csr_rdata   = (csr.csr_valid & ~ill) ? old : '0;

  assign op = csr.csr_use_imm ? {27'b0, csr.csr_zimm} : csr.csr_rs1;
  assign nv = (csr.csr_mode == MODE_RW) ? op :
              (csr.csr_mode == MODE_RS) ? (old | op) : (old & ~op);
  // Trap and mret both outrank a CSR write issued in the same cycle.
  assign do_wr = csr.csr_valid & csr.csr_wen & ~ill & ~trap_req & ~mret;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mie_r_d    = mie_r_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire};
    if (trap_req) begin
      mepc_d   = {trap_pc[31:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (do_wr) begin
      case (csr.csr_addr)
        12'h300: begin mie_d = nv[3]; mpie_d = nv[7]; end
        12'h304: mie_r_d    = nv;
        12'h305: mtvec_d    = {nv[31:2], 1'b0, nv[0]};
        12'h340: mscratch_d = nv;
        12'h341: mepc_d     = {nv[31:2], 2'b00};
        12'h342: mcause_d   = nv;
        12'h343: mtval_d    = nv;
        // A half-write replaces that half and swallows this cycle's increment.
        12'hB00: mcycle_d   = {mcycle_q[63:32], nv};
        12'hB80: mcycle_d   = {nv, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], nv};
        12'hB82: minstret_d = {nv, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  assign vec_base = {mtvec_q[31:2], 2'b00};
  always_comb begin
    redirect_pc = '0;
    if (trap_req)
      redirect_pc = (mtvec_q[0] & trap_cause[31]) ? vec_base + {trap_cause[29:0], 2'b00}
                                                  : vec_base;
    else if (mret)
      redirect_pc = mepc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_r_q    <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mie_r_q    <= mie_r_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// Random + directed bench for csr_file against an architectural CSR model.
module tb_csr_file;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_file_if cif();
  logic        retire = 0, trap_req = 0, mret = 0;
  logic [31:0] trap_cause = 0, trap_pc = 0, trap_tval = 0;
  logic [31:0] redirect_pc;
  logic        mstatus_mie;

  csr_file dut (
    .clk(clk), .rst_n(rst_n), .csr(cif.slave),
    .retire(retire), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
    .redirect_pc(redirect_pc), .mstatus_mie(mstatus_mie)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Architectural state of the reference model.
  logic        m_mie, m_mpie;
  logic [31:0] m_mier, m_mtvec, m_mscr, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = 0; m_mscr = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
  endfunction

  // bit 32 = address implemented
  function automatic logic [32:0] mread(input logic [11:0] a);
    logic [31:0] ms;
    ms = 32'h1800 | (m_mpie ? 32'h80 : 0) | (m_mie ? 32'h8 : 0);
    case (a)
      12'h300: return {1'b1, ms};
      12'h301: return {1'b1, 32'h4000_0100};
      12'h304: return {1'b1, m_mier};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscr};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'h344: return {1'b1, 32'h0};
      12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
      12'hF14: return {1'b1, 32'h0};
      default: return 33'h0;
    endcase
  endfunction

  // One clock: check combinational outputs against the model, then advance it.
  task automatic cyc();
    logic [32:0] r;
    logic [31:0] op, nw, e_rd, e_rp;
    logic        e_ill, n_mie, n_mpie;
    logic [31:0] n_mier, n_mtvec, n_mscr, n_mepc, n_mcause, n_mtval;
    logic [63:0] n_cyc, n_ins;
    @(negedge clk);
    r     = mread(cif.csr_addr);
    e_ill = cif.csr_valid && (!r[32] || cif.csr_mode == 2'b00 ||
            (cif.csr_wen && cif.csr_addr >= 12'hC00));
    e_rd  = (cif.csr_valid && !e_ill) ? r[31:0] : 32'h0;
    if (trap_req)
      e_rp = (m_mtvec[0] && trap_cause[31]) ?
             (m_mtvec & ~32'd3) + 32'(trap_cause[30:0]) * 4 : (m_mtvec & ~32'd3);
    else if (mret) e_rp = m_mepc;
    else           e_rp = 0;
    chk("rdata", cif.csr_rdata, e_rd);
    chk("illegal", {31'b0, cif.csr_illegal}, {31'b0, e_ill});
    chk("redirect", redirect_pc, e_rp);
    chk("mie_out", {31'b0, mstatus_mie}, {31'b0, m_mie});

    op = cif.csr_use_imm ? 32'(cif.csr_zimm) : cif.csr_rs1;
    case (cif.csr_mode)
      2'b01:   nw = op;
      2'b10:   nw = r[31:0] | op;
      default: nw = r[31:0] & ~op;
    endcase
    n_mie = m_mie; n_mpie = m_mpie; n_mier = m_mier; n_mtvec = m_mtvec;
    n_mscr = m_mscr; n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
    n_cyc = m_cyc + 1; n_ins = m_ins + (retire ? 64'd1 : 64'd0);
    if (trap_req) begin
      n_mepc = trap_pc & ~32'd3; n_mcause = trap_cause; n_mtval = trap_tval;
      n_mpie = m_mie; n_mie = 0;
    end else if (mret) begin
      n_mie = m_mpie; n_mpie = 1;
    end else if (cif.csr_valid && cif.csr_wen && !e_ill) begin
      case (cif.csr_addr)
        12'h300: begin n_mie = nw[3]; n_mpie = nw[7]; end
        12'h304: n_mier = nw;
        12'h305: n_mtvec = nw & ~32'd2;
        12'h340: n_mscr = nw;
        12'h341: n_mepc = nw & ~32'd3;
        12'h342: n_mcause = nw;
        12'h343: n_mtval = nw;
        12'hB00: n_cyc = {m_cyc[63:32], nw};
        12'hB80: n_cyc = {nw, m_cyc[31:0]};
        12'hB02: n_ins = {m_ins[63:32], nw};
        12'hB82: n_ins = {nw, m_ins[31:0]};
        default: ;
      endcase
    end
    @(posedge clk);
    m_mie = n_mie; m_mpie = n_mpie; m_mier = n_mier; m_mtvec = n_mtvec;
    m_mscr = n_mscr; m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
    m_cyc = n_cyc; m_ins = n_ins;
    #1;
  endtask

  task automatic idle();
    cif.csr_valid = 0; cif.csr_wen = 0; cif.csr_use_imm = 0; cif.csr_mode = 2'b10;
    cif.csr_addr = 0; cif.csr_rs1 = 0; cif.csr_zimm = 0;
    retire = 0; trap_req = 0; mret = 0;
  endtask

  task automatic set_csr(input logic w, input logic [1:0] md, input logic [11:0] a,
                         input logic [31:0] v);
    idle();
    cif.csr_valid = 1; cif.csr_wen = w; cif.csr_mode = md; cif.csr_addr = a; cif.csr_rs1 = v;
  endtask

  // Access with an explicit expected old value, then a model-checked cycle.
  task automatic acc(input string tag, input logic w, input logic [1:0] md,
                     input logic [11:0] a, input logic [31:0] v, input logic [31:0] exp);
    set_csr(w, md, a, v);
    #1 chk(tag, cif.csr_rdata, exp);
    cyc();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    m_reset();
    #1;
    chk("rst_rdata", cif.csr_rdata, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_mie", {31'b0, mstatus_mie}, 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  logic [11:0] alist [18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
    12'hC80, 12'hC02, 12'hC82, 12'hF14};

  initial begin
    idle();
    #3 do_reset();
    acc("mstatus_rst", 0, 2'b10, 12'h300, 0, 32'h0000_1800);
    acc("misa", 0, 2'b10, 12'h301, 0, 32'h4000_0100);
    acc("mhartid", 0, 2'b10, 12'hF14, 0, 32'h0);
    acc("mscr_rw", 1, 2'b01, 12'h340, 32'hA5A5_A5A5, 32'h0);
    acc("mscr_rs", 1, 2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_A5A5);
    acc("mscr_rd", 0, 2'b10, 12'h340, 0, 32'hA5A5_A5FF);

    set_csr(1, 2'b01, 12'hB00, 32'hFFFF_FFFF); cyc();
    set_csr(1, 2'b01, 12'hB80, 32'h0); cyc();
    idle(); cyc();
    acc("mcycleh_carry", 0, 2'b10, 12'hB80, 0, 32'h1);
    acc("mcycle_lo", 0, 2'b10, 12'hB00, 0, 32'h1);

    set_csr(1, 2'b01, 12'h305, 32'h101); cyc();
    set_csr(1, 2'b01, 12'h300, 32'h8); cyc();
    idle(); trap_req = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h204; trap_tval = 32'h55;
    #1 chk("trap_vec", redirect_pc, 32'h11C);
    cyc();
    acc("mepc_trap", 0, 2'b10, 12'h341, 0, 32'h204);
    acc("mstatus_trap", 0, 2'b10, 12'h300, 0, 32'h1880);
    idle(); mret = 1;
    #1 chk("mret_redirect", redirect_pc, 32'h204);
    cyc();
    idle();
    #1 chk("mret_mie", {31'b0, mstatus_mie}, 32'h1);
    acc("mstatus_mret", 0, 2'b10, 12'h300, 0, 32'h1888);

    set_csr(1, 2'b01, 12'hC00, 32'h1234);
    #1 chk("ro_illegal", {31'b0, cif.csr_illegal}, 32'h1);
    cyc();
    set_csr(1, 2'b01, 12'h7C0, 32'h1234);
    #1 chk("unimpl_illegal", {31'b0, cif.csr_illegal}, 32'h1);
    cyc();
    acc("mscr_kept", 0, 2'b10, 12'h340, 0, 32'hA5A5_A5FF);

    set_csr(1, 2'b01, 12'h341, 32'hDEAD_BEEF);
    trap_req = 1; trap_cause = 32'h2; trap_pc = 32'h300; trap_tval = 0;
    cyc();
    acc("trap_beats_wr", 0, 2'b10, 12'h341, 0, 32'h300);

    set_csr(1, 2'b01, 12'h304, 32'hFFFF_0000); cyc();
    idle(); cyc();
    #2 do_reset();
    acc("mstatus_rst2", 0, 2'b10, 12'h300, 0, 32'h1800);
    acc("mscr_rst2", 0, 2'b10, 12'h340, 0, 32'h0);
    acc("mtvec_rst2", 0, 2'b10, 12'h305, 0, 32'h0);
    acc("mie_r_rst2", 0, 2'b10, 12'h304, 0, 32'h0);

    for (int i = 0; i < 600; i++) begin
      int pick;
      idle();
      pick = $urandom_range(0, 20);
      cif.csr_valid   = ($urandom_range(0, 3) != 0);
      cif.csr_wen     = $urandom_range(0, 1);
      cif.csr_use_imm = $urandom_range(0, 1);
      cif.csr_mode    = 2'($urandom_range(0, 3));
      cif.csr_addr    = (pick < 18) ? alist[pick] : 12'($urandom);
      cif.csr_rs1     = $urandom;
      cif.csr_zimm    = 5'($urandom);
      retire          = $urandom_range(0, 1);
      trap_req        = ($urandom_range(0, 9) == 0);
      mret            = ($urandom_range(0, 7) == 0);
      trap_cause      = $urandom;
      trap_pc         = $urandom;
      trap_tval       = $urandom;
      cyc();
      if (i == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
